seq_divider8by4: RTL and testbench



---
 rtl/seq_divider8by4.sv | 125 ++++++++++++
 tb/tb_seq_divider8by4.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider8by4.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, with a
// start/busy/done handshake and a divide-by-zero flag.
module seq_divider8by4 #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] remo_q, remo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   trial;
    logic          qbit;
    logic [VW-1:0] rem_next;
    logic [DW-1:0] shift_next;

    always_comb begin
        // The restored remainder is always below the divisor, so only the trial
        // value needs the extra top bit; the low VW bits of the difference are exact.
        trial      = {rem_q, shift_q[DW-1]};
        qbit       = (trial >= {1'b0, dvsr_q});
        rem_next   = qbit ? (trial[VW-1:0] - dvsr_q) : trial[VW-1:0];
        shift_next = {shift_q[DW-2:0], qbit};

        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        shift_d = dividend;
                        rem_d   = '0;
                        dvsr_d  = divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        quot_d  = '1;
                        remo_d  = '0;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                shift_d = shift_next;
                rem_d   = rem_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    quot_d  = shift_next;
                    remo_d  = rem_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8by4.sv
// Bench for seq_divider8by4: directed cases plus random pairs, checked against
// plain integer division and the handshake timing rules.
module tb_seq_divider8by4;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    int total = 0;
    int bad   = 0;

    // Expected visible results (updated only when the model says a done occurs).
    int exp_q   = 0;
    int exp_r   = 0;
    int exp_dbz = 0;

    seq_divider8by4 #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one division from the current cycle. If poke_at >= 0, a 9/3 start is
    // driven for one cycle at that iteration and must be ignored.
    task automatic run_div(input int a, input int b, input int poke_at);
        int n;
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        step();
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        if (b == 0) begin
            exp_q   = 255;
            exp_r   = 0;
            exp_dbz = 1;
            chk("dbz_done", done, 1);
            chk("dbz_busy", busy, 0);
            chk("dbz_q", quotient, exp_q);
            chk("dbz_r", remainder, exp_r);
            chk("dbz_flag", div_by_zero, 1);
        end else begin
            n = 0;
            while (!done && n < 20) begin
                chk("run_busy", busy, 1);
                chk("run_q_held", quotient, exp_q);
                chk("run_r_held", remainder, exp_r);
                chk("run_dbz_clr", div_by_zero, 0);
                if (n == poke_at) begin
                    start    = 1'b1;
                    dividend = 8'd9;
                    divisor  = 4'd3;
                end else begin
                    start    = 1'b0;
                end
                step();
                n++;
            end
            start   = 1'b0;
            exp_q   = a / b;
            exp_r   = a % b;
            exp_dbz = 0;
            chk("latency", n, DW);
            chk("done", done, 1);
            chk("done_busy", busy, 0);
            chk("quot", quotient, exp_q);
            chk("rem", remainder, exp_r);
            chk("dbz", div_by_zero, 0);
            chk("invariant", 32'(quotient) * b + 32'(remainder), a);
            chk("rem_lt_div", 32'(remainder < VW'(b)), 1);
        end
    endtask

    task automatic idle_check();
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_q", quotient, exp_q);
        chk("idle_r", remainder, exp_r);
        chk("idle_dbz", div_by_zero, exp_dbz);
    endtask

    initial begin
        int a;
        int b;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        idle_check();

        // T1 / T2
        run_div(200, 7, -1);
        idle_check();
        run_div(255, 1, -1);
        run_div(5, 9, -1);
        run_div(0, 15, -1);
        idle_check();

        // T3, including back-to-back divide-by-zero keeping done high
        run_div(100, 0, -1);
        idle_check();
        run_div(5, 0, -1);
        run_div(6, 0, -1);
        idle_check();

        // T4: ignored start mid-run, then accepted start in the done cycle
        run_div(200, 7, 3);
        run_div(9, 3, -1);
        idle_check();

        // T5: reset at iteration 4 aborts without a done
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_q   = 0;
        exp_r   = 0;
        exp_dbz = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        for (int i = 0; i < 10; i++) idle_check();
        run_div(81, 9, -1);
        idle_check();

        // T6: exhaustive product round-trip, then random pairs
        for (int x = 1; x <= 15; x++) begin
            for (int y = 1; y <= 15; y++) begin
                run_div(x * y, y, -1);
            end
        end
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            run_div(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
